pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-flow controller for the single-cycle core: owns the program counter and sequences it through program start, sequential fetch, relative backward branches, pipeline stalls and halt. Sits between the testbench/host start–done handshake and the instruction ROM address port; decoder outputs (Halt, BranchRel) and the ALU Zero flag feed it each cycle. Also keeps a retired-instruction count for performance reporting.

## Interface
- W, 8, PC / instruction-address width
- CW, 16, InstrCount width

- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high
- Start  input  1  request to begin a program; sampled in IDLE and DONE only
- StartAddr  input  W  first instruction address, captured when Start is accepted
- Stall  input  1  hold current instruction; no PC/count update this cycle
- Halt  input  1  decoded halt at current PC (valid only while Running)
- BranchRel  input  1  decoded relative branch at current PC
- Zero  input  1  ALU zero flag; branch taken only when BranchRel & Zero
- Target  input  W  unsigned backward offset of a taken branch
- PC  output  W  current instruction address
- Running  output  1  current PC holds a valid executing instruction (state RUN)
- Done  output  1  program finished (state DONE)
- InstrCount  output  CW  instructions retired since last accepted Start

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: PC held, Running=0, Done=0. Start=1 -> PC<=StartAddr, InstrCount<=0, go RUN.
- RUN, Stall=1: PC, InstrCount, state unchanged; Halt/BranchRel/Zero/Start ignored.
- RUN, Stall=0: instruction at PC retires, InstrCount increments, then by priority:
  - Halt=1 -> PC held, go DONE (Halt beats a simultaneous taken branch).
  - BranchRel&Zero -> PC <= PC - Target.
  - else -> PC <= PC + 1.
- RUN, Start ignored (no restart mid-program).
- DONE: PC and InstrCount frozen, Done=1. Start=1 -> PC<=StartAddr, InstrCount<=0, go RUN (Done drops next cycle).
- Arithmetic: PC updates are modulo 2^W (PC+1 at 2^W-1 wraps to 0; PC-Target below 0 wraps). Target=0 taken -> PC unchanged (legal tight loop, still counts a retire).
- InstrCount saturates at 2^CW-1; never wraps.
- BranchRel=1 with Zero=0 behaves exactly as a non-branch (PC+1).

## Timing
- Reset values: PC=0, Running=0, Done=0, InstrCount=0, state IDLE; Reset overrides all inputs including Start and Stall, and takes effect at the edge it is sampled, from any state.
- Running and Done are decoded from state register only (no input-to-output combinational path).
- Start accepted at edge N -> PC=StartAddr and Running=1 from cycle N+1.
- One instruction retires per non-stalled RUN cycle; next PC visible the cycle after the retiring edge.
- Halt sampled at edge N -> Done=1, Running=0 from cycle N+1; PC keeps halt instruction's address.
- Stall length unbounded; releasing Stall resumes with the same PC and the then-current Halt/BranchRel/Zero.
- Start held high across DONE->RUN is accepted once; it is ignored while in RUN.

## Test plan
- Reset then Start with StartAddr=0x10, no branches, 5 cycles -> PC 0x10,0x11,..,0x15; InstrCount=5; Running=1, Done=0.
- RUN at PC=0x20, BranchRel=1, Zero=1, Target=0x05 -> next PC=0x1B; same with Zero=0 -> next PC=0x21.
- PC=0xFF, no branch -> PC=0x00; PC=0x02, taken branch Target=0x04 -> PC=0xFE.
- Stall high 3 cycles at PC=0x30 with Halt=1 and taken branch driven -> PC stays 0x30, InstrCount unchanged, state RUN; Stall low with Halt=1, BranchRel&Zero=1 -> Done=1 next cycle, PC=0x30, count+1.
- In DONE, Start with StartAddr=0x40 -> Running=1, PC=0x40, InstrCount=0 next cycle; Start pulses during RUN -> no effect.
- Reset asserted mid-RUN at PC=0x57 with Stall=1 -> next cycle PC=0, InstrCount=0, IDLE; force InstrCount to 0xFFFF via long loop (Target=0) -> stays 0xFFFF.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Host/decoder-side bundle of the program-flow controller: start handshake,
// per-cycle decode/ALU flags in, PC and status out.
interface pc_sequencer_if #(
    parameter int W  = 8,
    parameter int CW = 16
);
    logic          Start;
    logic [W-1:0]  StartAddr;
    logic          Stall;
    logic          Halt;
    logic          BranchRel;
    logic          Zero;
    logic [W-1:0]  Target;
    logic [W-1:0]  PC;
    logic          Running;
    logic          Done;
    logic [CW-1:0] InstrCount;

    modport master (
        output Start, StartAddr, Stall, Halt, BranchRel, Zero, Target,
        input  PC, Running, Done, InstrCount
    );

    modport slave (
        input  Start, StartAddr, Stall, Halt, BranchRel, Zero, Target,
        output PC, Running, Done, InstrCount
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/DONE flow with relative backward
// branches, stalls, halt and a saturating retired-instruction counter.
module pc_sequencer #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input logic          Clk,
    input logic          Reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CW-1:0] COUNT_MAX = '1;

    state_e        state_q, state_d;
    logic [W-1:0]  pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no
        // path through the case leaves a signal unassigned (no latches).
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    state_d = S_RUN;
                    pc_d    = bus.StartAddr;
                    count_d = '0;
                end
            end
            S_RUN: begin
                // A stalled cycle retires nothing and ignores decode inputs.
                if (!bus.Stall) begin
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + CW'(1);
                    end
                    if (bus.Halt) begin
                        state_d = S_DONE;
                    end else if (bus.BranchRel && bus.Zero) begin
                        pc_d = pc_q - bus.Target;
                    end else begin
                        pc_d = pc_q + W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status is decoded from the state register only.
    assign bus.PC         = pc_q;
    assign bus.Running    = (state_q == S_RUN);
    assign bus.Done       = (state_q == S_DONE);
    assign bus.InstrCount = count_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a program-level model checked against the
// DUT every cycle, plus literal expectations at the interesting points.
module tb_pc_sequencer;
    logic Clk;
    logic Reset;

    pc_sequencer_if #(.W(8), .CW(16)) bus ();

    pc_sequencer #(.W(8), .CW(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total;
    int bad;
    bit checking;

    // Program-level model: PC as an integer modulo 256, count clipped at 65535.
    int m_pc;
    int m_cnt;
    bit m_run;
    bit m_done;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            m_pc   = 0;
            m_cnt  = 0;
            m_run  = 0;
            m_done = 0;
        end else if (!m_run) begin
            if (bus.Start) begin
                m_pc   = int'(bus.StartAddr);
                m_cnt  = 0;
                m_run  = 1;
                m_done = 0;
            end
        end else if (!bus.Stall) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (bus.Halt) begin
                m_run  = 0;
                m_done = 1;
            end else if (bus.BranchRel && bus.Zero) begin
                m_pc = (m_pc - int'(bus.Target) + 256) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    always @(negedge Clk) begin
        if (checking) begin
            check("model_pc",      32'(bus.PC),         32'(m_pc));
            check("model_count",   32'(bus.InstrCount), 32'(m_cnt));
            check("model_running", 32'(bus.Running),    32'(m_run));
            check("model_done",    32'(bus.Done),       32'(m_done));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_decode();
        bus.Halt      = 1'b0;
        bus.BranchRel = 1'b0;
        bus.Zero      = 1'b0;
        bus.Target    = 8'h00;
        bus.Stall     = 1'b0;
    endtask

    // Halt whatever is running, then start a fresh program at addr.
    task automatic restart(input logic [7:0] addr);
        clear_decode();
        bus.Halt = 1'b1;
        tick(1);
        bus.Halt      = 1'b0;
        bus.Start     = 1'b1;
        bus.StartAddr = addr;
        tick(1);
        bus.Start = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        checking = 0;
        Reset    = 1'b1;
        bus.Start     = 1'b0;
        bus.StartAddr = 8'h00;
        clear_decode();
        tick(1);
        checking = 1;
        tick(1);
        Reset = 1'b0;

        // Reset state, and IDLE holds without Start.
        check("reset_pc",      32'(bus.PC),         32'h0);
        check("reset_running", 32'(bus.Running),    32'h0);
        check("reset_done",    32'(bus.Done),       32'h0);
        tick(2);
        check("idle_pc",       32'(bus.PC),         32'h0);

        // Sequential fetch from 0x10.
        bus.Start     = 1'b1;
        bus.StartAddr = 8'h10;
        tick(1);
        bus.Start = 1'b0;
        check("start_pc",      32'(bus.PC),         32'h10);
        check("start_running", 32'(bus.Running),    32'h1);
        tick(5);
        check("seq_pc",        32'(bus.PC),         32'h15);
        check("seq_count",     32'(bus.InstrCount), 32'd5);
        check("seq_done",      32'(bus.Done),       32'h0);

        // Taken and not-taken branch at 0x20.
        restart(8'h20);
        bus.BranchRel = 1'b1;
        bus.Zero      = 1'b1;
        bus.Target    = 8'h05;
        tick(1);
        check("br_taken_pc",   32'(bus.PC),         32'h1B);
        restart(8'h20);
        bus.BranchRel = 1'b1;
        bus.Zero      = 1'b0;
        bus.Target    = 8'h05;
        tick(1);
        check("br_nottaken_pc", 32'(bus.PC),        32'h21);

        // Wraparound both directions.
        restart(8'hFF);
        tick(1);
        check("wrap_inc_pc",   32'(bus.PC),         32'h00);
        restart(8'h02);
        bus.BranchRel = 1'b1;
        bus.Zero      = 1'b1;
        bus.Target    = 8'h04;
        tick(1);
        check("wrap_br_pc",    32'(bus.PC),         32'hFE);

        // Stall beats halt and branch; on release halt beats the branch.
        restart(8'h30);
        bus.Stall     = 1'b1;
        bus.Halt      = 1'b1;
        bus.BranchRel = 1'b1;
        bus.Zero      = 1'b1;
        bus.Target    = 8'h03;
        tick(3);
        check("stall_pc",      32'(bus.PC),         32'h30);
        check("stall_count",   32'(bus.InstrCount), 32'd0);
        check("stall_running", 32'(bus.Running),    32'h1);
        bus.Stall = 1'b0;
        tick(1);
        check("halt_done",     32'(bus.Done),       32'h1);
        check("halt_running",  32'(bus.Running),    32'h0);
        check("halt_pc",       32'(bus.PC),         32'h30);
        check("halt_count",    32'(bus.InstrCount), 32'd1);
        clear_decode();
        tick(2);
        check("done_frozen_pc", 32'(bus.PC),        32'h30);

        // Restart from DONE with Start held high, then Start pulses in RUN.
        bus.Start     = 1'b1;
        bus.StartAddr = 8'h40;
        tick(1);
        check("rs_running",    32'(bus.Running),    32'h1);
        check("rs_pc",         32'(bus.PC),         32'h40);
        check("rs_count",      32'(bus.InstrCount), 32'd0);
        tick(2);
        bus.Start     = 1'b0;
        check("held_start_pc", 32'(bus.PC),         32'h42);
        bus.Start     = 1'b1;
        bus.StartAddr = 8'h77;
        tick(1);
        bus.Start = 1'b0;
        check("pulse_start_pc",    32'(bus.PC),         32'h43);
        check("pulse_start_count", 32'(bus.InstrCount), 32'd3);

        // Reset mid-run while stalled, with Start also high.
        restart(8'h57);
        bus.Stall = 1'b1;
        bus.Start = 1'b1;
        Reset     = 1'b1;
        tick(1);
        Reset     = 1'b0;
        bus.Start = 1'b0;
        bus.Stall = 1'b0;
        check("mid_reset_pc",      32'(bus.PC),         32'h0);
        check("mid_reset_count",   32'(bus.InstrCount), 32'd0);
        check("mid_reset_running", 32'(bus.Running),    32'h0);

        // Tight loop with Target=0 until the counter saturates.
        restart(8'h60);
        bus.BranchRel = 1'b1;
        bus.Zero      = 1'b1;
        bus.Target    = 8'h00;
        tick(65540);
        check("sat_count",     32'(bus.InstrCount), 32'hFFFF);
        check("sat_pc",        32'(bus.PC),         32'h60);
        tick(3);
        check("sat_hold",      32'(bus.InstrCount), 32'hFFFF);
        restart(8'h61);
        check("sat_clear",     32'(bus.InstrCount), 32'd0);
        check("sat_clear_pc",  32'(bus.PC),         32'h61);

        tick(1);
        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
